// File: rtl/store_buffer_pkg.sv
// Shared types and store-kind codes for the store buffer.
// Entry layout matches what the data-memory write port consumes.
package store_buffer_pkg;

    localparam int SB_DEPTH = 2;

    localparam logic [2:0] SL_WORD   = 3'd1;
    localparam logic [2:0] SL_HALF   = 3'd2;
    localparam logic [2:0] SL_BYTE   = 3'd3;
    localparam logic [2:0] SL_WLEFT  = 3'd4;
    localparam logic [2:0] SL_WRIGHT = 3'd5;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_format.sv
// Combinational lane formatter: byte enables and aligned data per store kind.
// Alignment legality only constrains sw and sh.
module store_buffer_format
    import store_buffer_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [31:0] rt_i,
    input  logic [2:0]  ctrl_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        legal_o,
    output logic        is_store_o,
    output logic        align_kind_o
);

    always_comb begin
        wdata_o      = '0;
        be_o         = '0;
        legal_o      = 1'b0;
        is_store_o   = 1'b0;
        align_kind_o = 1'b0;
        unique case (ctrl_i)
            SL_WORD: begin
                wdata_o      = rt_i;
                be_o         = 4'b1111;
                legal_o      = (addr_i == 2'b00);
                is_store_o   = 1'b1;
                align_kind_o = 1'b1;
            end
            SL_HALF: begin
                wdata_o      = {2{rt_i[15:0]}};
                be_o         = addr_i[1] ? 4'b1100 : 4'b0011;
                legal_o      = !addr_i[0];
                is_store_o   = 1'b1;
                align_kind_o = 1'b1;
            end
            SL_BYTE: begin
                wdata_o    = {4{rt_i[7:0]}};
                be_o       = 4'b0001 << addr_i;
                legal_o    = 1'b1;
                is_store_o = 1'b1;
            end
            // swl keeps the high bytes of rt in the low lanes up to b
            SL_WLEFT: begin
                wdata_o    = rt_i >> {~addr_i, 3'b000};
                be_o       = 4'b1111 >> (~addr_i);
                legal_o    = 1'b1;
                is_store_o = 1'b1;
            end
            SL_WRIGHT: begin
                wdata_o    = rt_i << {addr_i, 3'b000};
                be_o       = 4'b1111 << addr_i;
                legal_o    = 1'b1;
                is_store_o = 1'b1;
            end
            default: begin
                wdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Small in-order store FIFO between MEM stage and the data-memory write port.
// Also flags loads whose word is still buffered.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_ctrl,
    output logic        addr_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        empty
);

    localparam logic [PTRW:0] FULL = (PTRW + 1)'(DEPTH);

    sb_entry_t         ent_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTRW:0]     count_q, count_d;
    logic              err_q, err_d;

    logic [31:0] f_wdata;
    logic [3:0]  f_be;
    logic        f_legal;
    logic        f_is_store;
    logic        f_align_kind;
    logic        push, pop, offer;
    sb_entry_t   head, new_ent;

    store_buffer_format u_format (
        .addr_i       (req_addr[1:0]),
        .rt_i         (req_data),
        .ctrl_i       (req_ctrl),
        .wdata_o      (f_wdata),
        .be_o         (f_be),
        .legal_o      (f_legal),
        .is_store_o   (f_is_store),
        .align_kind_o (f_align_kind)
    );

    assign req_ready = (count_q != FULL);
    assign empty     = (count_q == '0);
    assign mem_valid = !empty;

    assign offer = req_valid & req_ready & f_is_store;
    assign push  = offer & f_legal;
    assign pop   = mem_valid & mem_ready;

    assign new_ent = '{addr: req_addr[31:2], data: f_wdata, be: f_be};
    assign head    = ent_q[rd_ptr_q];

    assign mem_addr  = mem_valid ? {head.addr, 2'b00} : '0;
    assign mem_wdata = mem_valid ? head.data : '0;
    assign mem_be    = mem_valid ? head.be : '0;
    assign addr_err  = err_q;

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && ent_q[i].addr == ld_addr[31:2]) begin
                ld_hit = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        err_d    = offer & f_align_kind & !f_legal;
        if (pop) begin
            rd_ptr_d        = rd_ptr_q + 1'b1;
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            vld_d[wr_ptr_q] = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            if (push) begin
                ent_q[wr_ptr_q] <= new_ent;
            end
        end
    end

endmodule
